// File: rtl/freq_div_pkg.sv
// Shared types and constants for the frequency-divider configuration sequencer.
package freq_div_pkg;

    localparam int unsigned DIV_W = 8;

    localparam logic [DIV_W-1:0] DIV_BYPASS0 = 8'h00;
    localparam logic [DIV_W-1:0] DIV_BYPASS1 = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/freq_div_shadow_bank.sv
// Per-channel shadow ratios plus dirty bits. Writes land on the next clk edge.
// There is no backpressure: the caller gates wr_en and clears committed channels via clr_mask.
module freq_div_shadow_bank
    import freq_div_pkg::*;
#(
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     DW          = DIV_W,
    parameter logic [DW-1:0]   DEFAULT_DIV = DW'(DIV_BYPASS0)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [3:0]           wr_ch,
    input  logic [DW-1:0]        wr_data,
    input  logic [N_CH-1:0]      clr_mask,
    output logic [N_CH*DW-1:0]   shadow,
    output logic [N_CH-1:0]      dirty,
    output logic [N_CH-1:0]      dirty_nxt
);

    logic [N_CH-1:0][DW-1:0] shadow_q, shadow_d;
    logic [N_CH-1:0]         dirty_q, dirty_d;

    // dirty_nxt folds in this cycle's write so a same-cycle commit includes it.
    always_comb begin
        shadow_d  = shadow_q;
        dirty_nxt = dirty_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && wr_ch == 4'(i)) begin
                shadow_d[i]  = wr_data;
                dirty_nxt[i] = 1'b1;
            end
        end
        dirty_d = dirty_nxt & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= {N_CH{DEFAULT_DIV}};
            dirty_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end

    assign shadow = shadow_q;
    assign dirty  = dirty_q;

endmodule

// File: rtl/freq_div_cfg_ctrl.sv
// Commits shadow divide ratios atomically to N_CH dividers and pulses their resets so they restart aligned.
// commit_done follows commit_req by 2+RST_CYCLES cycles; writes stall (wr_ready=0) whenever busy.
module freq_div_cfg_ctrl
    import freq_div_pkg::*;
#(
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     DW          = DIV_W,
    parameter int unsigned     RST_CYCLES  = 2,
    parameter logic [DW-1:0]   DEFAULT_DIV = DW'(DIV_BYPASS0)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_ch,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_err,
    input  logic                 commit_req,
    input  logic                 align_all,
    output logic                 busy,
    output logic                 commit_done,
    output logic [N_CH-1:0]      dirty,
    output logic [N_CH*DW-1:0]   div_data,
    output logic [N_CH-1:0]      div_rst
);

    localparam int unsigned CW = $clog2(RST_CYCLES + 1);

    state_e               state_q, state_d;
    logic [N_CH-1:0]      mask_q, mask_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 wr_err_q, wr_err_d;
    logic                 busy_q, busy_d;
    logic                 commit_done_q, commit_done_d;
    logic [N_CH*DW-1:0]   div_data_q, div_data_d;
    logic [N_CH-1:0]      div_rst_q, div_rst_d;

    logic                 wr_fire;
    logic                 ch_ok;
    logic [N_CH-1:0]      clr_mask;
    logic [N_CH*DW-1:0]   shadow;
    logic [N_CH-1:0]      dirty_cur;
    logic [N_CH-1:0]      dirty_nxt;

    // wr_ready_q is only high in IDLE, so it doubles as the write-window qualifier.
    assign wr_fire = wr_valid & wr_ready_q;
    assign ch_ok   = ({1'b0, wr_ch} < 5'(N_CH));

    freq_div_shadow_bank #(
        .N_CH        (N_CH),
        .DW          (DW),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_fire & ch_ok),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .clr_mask  (clr_mask),
        .shadow    (shadow),
        .dirty     (dirty_cur),
        .dirty_nxt (dirty_nxt)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        div_data_d = div_data_q;
        clr_mask   = '0;

        case (state_q)
            IDLE: begin
                if (align_all || (commit_req && dirty_nxt != '0)) begin
                    state_d = LOAD;
                    mask_d  = align_all ? '1 : dirty_nxt;
                end
            end
            LOAD: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (mask_q[i]) begin
                        div_data_d[i*DW +: DW] = shadow[i*DW +: DW];
                    end
                end
                cnt_d   = CW'(RST_CYCLES);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q <= CW'(1)) begin
                    state_d  = RELEASE;
                    clr_mask = mask_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered against the next state so they line up with it.
        wr_ready_d    = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        commit_done_d = (state_d == RELEASE);
        div_rst_d     = (state_d == HOLD) ? mask_d : '0;
        wr_err_d      = wr_fire & ~ch_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            cnt_q         <= '0;
            wr_ready_q    <= 1'b0;
            wr_err_q      <= 1'b0;
            busy_q        <= 1'b0;
            commit_done_q <= 1'b0;
            div_data_q    <= {N_CH{DEFAULT_DIV}};
            div_rst_q     <= '1;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            wr_ready_q    <= wr_ready_d;
            wr_err_q      <= wr_err_d;
            busy_q        <= busy_d;
            commit_done_q <= commit_done_d;
            div_data_q    <= div_data_d;
            div_rst_q     <= div_rst_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign wr_err      = wr_err_q;
    assign busy        = busy_q;
    assign commit_done = commit_done_q;
    assign dirty       = dirty_cur;
    assign div_data    = div_data_q;
    assign div_rst     = div_rst_q;

endmodule

// File: doc/freq_div_cfg_ctrl.md
Name: freq_div_cfg_ctrl

Overview:
Configuration sequencer for a bank of N 8-bit multiplexed frequency dividers. Accepts per-channel divide-ratio writes into shadow registers, then commits them atomically on request. Drives each divider's divide_data, and pulses each divider's rst so the divider samples the new ratio and restarts phase-aligned. Sits between the control register interface and the divider instances.

Parameters:
N_CH, 4, number of divider channels (1..16)
DW, 8, divide-ratio width (matches divider)
RST_CYCLES, 2, cycles div_rst is held during a commit (>=1)
DEFAULT_DIV, 8'h00, reset value of shadow/active ratios (0/1 = divider bypass)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_ch  in  4  target channel index
wr_data  in  DW  new divide ratio
wr_err  out  1  1-cycle pulse: write to wr_ch>=N_CH dropped
commit_req  in  1  apply dirty shadows (level or pulse; sampled in IDLE only)
align_all  in  1  commit and restart ALL channels regardless of dirty
busy  out  1  high in any state other than IDLE
commit_done  out  1  1-cycle pulse on RELEASE
dirty  out  N_CH  shadow differs from active / written since last commit
div_data  out  N_CH*DW  active ratio per channel, ch i at [i*DW +: DW]
div_rst  out  N_CH  per-channel divider reset

Behaviour:
- Reset values: wr_ready=0, wr_err=0, busy=0, commit_done=0, dirty=0, div_data=all DEFAULT_DIV, shadow=DEFAULT_DIV, div_rst=all ones (dividers held while rst high). State goes to IDLE.
- FSM states: IDLE, LOAD, HOLD, RELEASE. All outputs are registered.
- IDLE: wr_ready=1 and div_rst=0. An accepted write with wr_ch<N_CH sets shadow[wr_ch]<=wr_data and dirty[wr_ch]<=1. A write with wr_ch>=N_CH pulses wr_err next cycle and changes no state. Rewriting a channel before commit overwrites the shadow (last write wins).
- IDLE->LOAD when align_all=1, or when commit_req=1 and (dirty!=0 or a valid write is accepted the same cycle). commit_req with nothing dirty is ignored: no pulse, no state change.
- Simultaneous write+commit in IDLE: the write is accepted and included in the commit.
- Latched target mask: align_all ? all ones : dirty_next.
- LOAD (1 cycle): div_data[ch] <= shadow[ch] for masked channels. Unmasked channels keep their value. wr_ready=0.
- HOLD (exactly RST_CYCLES cycles): div_rst=mask and div_data stable, so each divider samples its new ratio while in reset. Counter width is clog2(RST_CYCLES+1).
- RELEASE (1 cycle): div_rst=0, dirty<=0 for masked channels, commit_done=1. Then go to IDLE.
- Commit latency: from the commit_req cycle to commit_done is 2+RST_CYCLES cycles (4 at default).
- commit_req/align_all outside IDLE are ignored, not queued. wr_valid outside IDLE stalls (wr_ready=0) and must be held by the master.
- align_all with commit_req: treated as align_all.
- rst asserted mid-sequence aborts immediately. All state returns to reset values, including shadow and dirty; pending writes are lost.
- No arithmetic beyond the HOLD counter. Ratios pass through unmodified; 0/1 is legal (bypass).

Decomposition:
- Shared package freq_div_pkg: DIV_W=8, state enum {IDLE, LOAD, HOLD, RELEASE}, DIV_BYPASS constants 8'h00/8'h01.
- One natural sub-module, freq_div_shadow_bank: the N_CH×DW shadow array plus dirty bits, with write port, mask-clear and reset.
- The FSM and outputs stay in the top.

Test Plan:
1. Reset release -> div_rst all ones during rst and 0 in the first IDLE cycle; div_data all 8'h00; wr_ready=1 one cycle after rst drops.
2. Write ch1=8'd10, ch3=8'd6, then commit_req -> dirty=4'b1010. div_data ch1=10, ch3=6 with ch0/ch2 unchanged. div_rst=4'b1010 for exactly 2 cycles. commit_done 4 cycles after commit_req; dirty=0 afterwards.
3. commit_req with dirty=0 -> busy stays 0 and no commit_done. Then align_all with no writes -> div_rst=4'b1111 for 2 cycles and commit_done pulses.
4. Write wr_ch=5 with N_CH=4 -> wr_err 1-cycle pulse, dirty unchanged. Same-cycle write ch2=8'd4 + commit_req -> ch2=4 committed, mask 4'b0100.
5. wr_valid held during HOLD -> wr_ready=0 and no shadow change. The write is accepted the first IDLE cycle after commit_done; a commit_req pulse during busy produces no second commit.
6. rst asserted in HOLD -> next cycle div_rst all ones, dirty=0, shadows=DEFAULT_DIV. After release, commit_req alone does nothing.
